frame_checker_impl: RTL and testbench

FRAME_CHECKER_IMPL -- requirements
Module: frame_checker_impl

---
 rtl/frame_checker_impl.sv | 167 ++++++++++++++++
 tb/tb_frame_checker_impl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_checker_impl.sv
// frame_checker_impl: AXI-Stream sink that parses Ethernet/IPv4 test frames and
// keeps running statistics of good, bad and ignored frames.
`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'hB8
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'h11
`endif

module frame_checker_impl #(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic [DATA_WIDTH-1:0]   axis_s_data,
   input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
   input  logic                    axis_s_last,
   input  logic [DATA_WIDTH/8-1:0] axis_s_user,
   input  logic [ID_WIDTH-1:0]     axis_s_id,
   input  logic                    axis_s_valid,
   output logic                    axis_s_ready,
   output logic [63:0]             frame_count,
   output logic [63:0]             byte_count,
   output logic [31:0]             error_count,
   output logic [31:0]             ignored_count,
   output logic                    frame_done,
   output logic                    frame_error
);
   localparam int KEEP_W  = DATA_WIDTH/8;
   localparam int HDR_END = 34*8;

   typedef enum logic {STATE_FIRST, STATE_BODY} state_t;
   state_t state, state_nxt;

   function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
      logic [15:0] cnt;
      cnt = '0;
      for (int i = 0; i < KEEP_W; i++) cnt = cnt + 16'(k[i]);
      return cnt;
   endfunction

   // Bit 16 flags that the frame length has passed 0xFFFF; the value then sticks at 0xFFFF.
   function automatic logic [16:0] len_add(input logic [15:0] acc, input logic ovf,
                                           input logic [15:0] inc);
      logic [16:0] s;
      s = {1'b0, acc} + {1'b0, inc};
      if (ovf || s[16]) return 17'h1FFFF;
      return s;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   // One's-complement sum of the ten header words in bytes 14..33, carries folded back.
   function automatic logic [15:0] hdr_sum(input logic [DATA_WIDTH-1:0] d);
      logic [19:0] acc;
      acc = '0;
      for (int i = 0; i < 10; i++)
         acc = acc + {4'h0, d[8*(14+2*i) +: 8], d[8*(15+2*i) +: 8]};
      acc = {4'h0, acc[15:0]} + {16'h0, acc[19:16]};
      acc = {4'h0, acc[15:0]} + {16'h0, acc[19:16]};
      return acc[15:0];
   endfunction

   logic [15:0] ethertype_q, ip_len_q, csum_q, len_acc;
   logic [7:0]  ver_ihl_q, tos_q, proto_q;
   logic        len_ovf;

   logic        xfer, first, fin, is_test, err, len_ovf_tot;
   logic [15:0] ethertype_c, ip_len_c, csum_c, len_tot;
   logic [7:0]  ver_ihl_c, tos_c, proto_c;
   logic [16:0] len_res;
   logic        unused_ok;

   assign axis_s_ready = rst_n;
   assign xfer  = axis_s_valid & axis_s_ready;
   assign first = (state == STATE_FIRST);
   assign fin   = xfer & axis_s_last;
   assign unused_ok = ^{axis_s_user, axis_s_id, axis_s_data[DATA_WIDTH-1:HDR_END],
                        axis_s_data[95:0]};

   // A single-beat frame is checked straight from the bus, so header fields bypass the latches.
   assign ethertype_c = first ? {axis_s_data[8*12 +: 8], axis_s_data[8*13 +: 8]} : ethertype_q;
   assign ver_ihl_c   = first ? axis_s_data[8*14 +: 8] : ver_ihl_q;
   assign tos_c       = first ? axis_s_data[8*15 +: 8] : tos_q;
   assign ip_len_c    = first ? {axis_s_data[8*16 +: 8], axis_s_data[8*17 +: 8]} : ip_len_q;
   assign proto_c     = first ? axis_s_data[8*23 +: 8] : proto_q;
   assign csum_c      = first ? hdr_sum(axis_s_data) : csum_q;

   assign len_res     = len_add(first ? 16'd0 : len_acc, first ? 1'b0 : len_ovf,
                                popcount(axis_s_keep));
   assign len_tot     = len_res[15:0];
   assign len_ovf_tot = len_res[16];

   assign is_test = (ethertype_c == 16'h0800) && (tos_c == `TEST_FRAME_TOS) &&
                    (proto_c == `TEST_FRAME_PROTO);
   assign err     = (ver_ihl_c != 8'h45) || (csum_c != 16'hFFFF) ||
                    (ip_len_c != len_tot - 16'd14) || (len_tot < 16'd34) || len_ovf_tot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= STATE_FIRST;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (xfer) state_nxt = axis_s_last ? STATE_FIRST : STATE_BODY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ethertype_q <= '0;
         ver_ihl_q   <= '0;
         tos_q       <= '0;
         ip_len_q    <= '0;
         proto_q     <= '0;
         csum_q      <= '0;
         len_acc     <= '0;
         len_ovf     <= 1'b0;
      end else if (xfer) begin
         if (first) begin
            ethertype_q <= ethertype_c;
            ver_ihl_q   <= ver_ihl_c;
            tos_q       <= tos_c;
            ip_len_q    <= ip_len_c;
            proto_q     <= proto_c;
            csum_q      <= csum_c;
         end
         len_acc <= axis_s_last ? 16'd0 : len_tot;
         len_ovf <= axis_s_last ? 1'b0 : len_ovf_tot;
      end
   end

   // Frame result stage: one cycle after the last beat is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count   <= '0;
         byte_count    <= '0;
         error_count   <= '0;
         ignored_count <= '0;
         frame_done    <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         frame_done  <= fin;
         frame_error <= fin & is_test & err;
         if (clear) begin
            frame_count   <= '0;
            byte_count    <= '0;
            error_count   <= '0;
            ignored_count <= '0;
         end else if (fin) begin
            if (!is_test) begin
               ignored_count <= sat_inc32(ignored_count);
            end else if (err) begin
               error_count <= sat_inc32(error_count);
            end else begin
               frame_count <= frame_count + 64'd1;
               byte_count  <= byte_count + {48'd0, len_tot};
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_checker_impl.sv
// Scoreboard bench for frame_checker_impl: directed frames push expected results,
// a monitor pops and compares on every frame_done pulse.
module tb_frame_checker_impl;
   localparam int DW = 512;
   localparam int KW = DW/8;
   localparam logic [7:0] TOS   = 8'hB8;
   localparam logic [7:0] PROTO = 8'h11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic [KW-1:0] s_keep = '0;
   logic          s_last = 1'b0;
   logic [KW-1:0] s_user = '0;
   logic [2:0]    s_id = 3'd5;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [63:0]   frame_count, byte_count;
   logic [31:0]   error_count, ignored_count;
   logic          frame_done, frame_error;

   typedef struct {
      logic        err;
      logic [63:0] fc;
      logic [63:0] bc;
      logic [31:0] ec;
      logic [31:0] ic;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [7:0] hdr [0:33];

   frame_checker_impl #(.DATA_WIDTH(DW), .ID_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .axis_s_data(s_data), .axis_s_keep(s_keep), .axis_s_last(s_last),
      .axis_s_user(s_user), .axis_s_id(s_id), .axis_s_valid(s_valid),
      .axis_s_ready(s_ready), .frame_count(frame_count), .byte_count(byte_count),
      .error_count(error_count), .ignored_count(ignored_count),
      .frame_done(frame_done), .frame_error(frame_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic err, input logic [63:0] fc, input logic [63:0] bc,
                               input logic [31:0] ec, input logic [31:0] ic);
      exp_t e;
      e.err = err; e.fc = fc; e.bc = bc; e.ec = ec; e.ic = ic; e.cyc = 0;
      return e;
   endfunction

   // Header with a correct IPv4 checksum; flip corrupts one address bit afterwards.
   task automatic build_hdr(input logic [15:0] et, input logic [7:0] vihl,
                            input logic [15:0] iplen, input bit flip);
      logic [19:0] s;
      for (int i = 0; i < 12; i++) hdr[i] = 8'(8'h10 + i);
      hdr[12] = et[15:8];    hdr[13] = et[7:0];
      hdr[14] = vihl;        hdr[15] = TOS;
      hdr[16] = iplen[15:8]; hdr[17] = iplen[7:0];
      hdr[18] = 8'h12; hdr[19] = 8'h34; hdr[20] = 8'h40; hdr[21] = 8'h00;
      hdr[22] = 8'h40; hdr[23] = PROTO; hdr[24] = 8'h00; hdr[25] = 8'h00;
      hdr[26] = 8'hC0; hdr[27] = 8'hA8; hdr[28] = 8'h00; hdr[29] = 8'h01;
      hdr[30] = 8'hC0; hdr[31] = 8'hA8; hdr[32] = 8'h00; hdr[33] = 8'h02;
      s = '0;
      for (int i = 14; i < 34; i += 2) s = s + {4'h0, hdr[i], hdr[i+1]};
      s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
      s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
      hdr[24] = ~s[15:8];
      hdr[25] = ~s[7:0];
      if (flip) hdr[26][0] = ~hdr[26][0];
   endtask

   function automatic logic [7:0] byte_at(input int k);
      if (k < 34) return hdr[k];
      return 8'(k * 7);
   endfunction

   // stop_beats > 0 leaves that beat on the bus (valid high) and returns without finishing.
   task automatic send_frame(input int len, input bit gaps, input bit clr_last,
                             input int stop_beats, input exp_t e);
      int nb;
      nb = (len + KW - 1) / KW;
      for (int b = 0; b < nb; b++) begin
         @(negedge clk);
         for (int j = 0; j < KW; j++) begin
            if (b*KW + j < len) begin
               s_data[8*j +: 8] = byte_at(b*KW + j);
               s_keep[j] = 1'b1;
            end else begin
               s_data[8*j +: 8] = 8'hEE;
               s_keep[j] = 1'b0;
            end
         end
         s_valid = 1'b1;
         s_last  = (b == nb-1);
         clear   = clr_last && (b == nb-1);
         if (stop_beats > 0 && b == stop_beats-1) return;
         if (b == nb-1) begin
            e.cyc = cyc + 1;
            sb.push_back(e);
         end
         if (gaps && b != nb-1) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b1;
            s_keep  = '1;
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      clear   = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (frame_done === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: frame_done=1 with no frame pending at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("done_cycle",    64'(cyc),           64'(e.cyc));
               chk("frame_error",   64'(frame_error),   64'(e.err));
               chk("frame_count",   frame_count,        e.fc);
               chk("byte_count",    byte_count,         e.bc);
               chk("error_count",   64'(error_count),   64'(e.ec));
               chk("ignored_count", 64'(ignored_count), 64'(e.ic));
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      exp_t dummy;
      dummy = mk(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst_ready",   64'(s_ready),       64'd0);
      chk("rst_done",    64'(frame_done),    64'd0);
      chk("rst_error",   64'(frame_error),   64'd0);
      chk("rst_fc",      frame_count,        64'd0);
      chk("rst_bc",      byte_count,         64'd0);
      chk("rst_ec",      64'(error_count),   64'd0);
      chk("rst_ic",      64'(ignored_count), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", 64'(s_ready), 64'd1);

      build_hdr(16'h0800, 8'h45, 16'd50, 0);
      send_frame(64, 0, 0, 0, mk(0, 1, 64, 0, 0));
      build_hdr(16'h0800, 8'h45, 16'd1504, 0);
      send_frame(1518, 0, 0, 0, mk(0, 2, 1582, 0, 0));
      build_hdr(16'h0800, 8'h45, 16'd50, 1);
      send_frame(64, 0, 0, 0, mk(1, 2, 1582, 1, 0));
      build_hdr(16'h0806, 8'h45, 16'd50, 0);
      send_frame(64, 0, 0, 0, mk(0, 2, 1582, 1, 1));
      build_hdr(16'h0800, 8'h45, 16'd114, 0);
      send_frame(128, 1, 0, 0, mk(0, 3, 1710, 1, 1));
      build_hdr(16'h0800, 8'h45, 16'd60, 0);
      send_frame(64, 0, 0, 0, mk(1, 3, 1710, 2, 1));
      build_hdr(16'h0800, 8'h45, 16'd16, 0);
      send_frame(30, 0, 0, 0, mk(1, 3, 1710, 3, 1));
      build_hdr(16'h0800, 8'h46, 16'd50, 0);
      send_frame(64, 0, 0, 0, mk(1, 3, 1710, 4, 1));
      build_hdr(16'h0800, 8'h45, 16'd65521, 0);
      send_frame(65600, 0, 0, 0, mk(1, 3, 1710, 5, 1));
      build_hdr(16'h0800, 8'h45, 16'd50, 0);
      send_frame(64, 0, 1, 0, mk(0, 0, 0, 0, 0));
      send_frame(64, 0, 0, 0, mk(0, 1, 64, 0, 0));

      build_hdr(16'h0800, 8'h45, 16'd306, 0);
      send_frame(320, 0, 0, 3, dummy);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("midrst_ready", 64'(s_ready),     64'd0);
      chk("midrst_fc",    frame_count,      64'd0);
      chk("midrst_ec",    64'(error_count), 64'd0);
      rst_n = 1'b1;
      build_hdr(16'h0800, 8'h45, 16'd114, 0);
      send_frame(128, 0, 0, 0, mk(0, 1, 128, 0, 0));

      repeat (3) @(negedge clk);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
